dma_ping_pong_buffer: RTL and testbench
=======================================

# dma_ping_pong_buffer

Two-bank ping-pong word buffer that sits directly beside the DMA engine on its buffer interface. The DMA side accesses one bank. The host side (JTAG/CPU) accesses the other bank in parallel. A switch request from either side swaps the banks atomically. Per-bank fill counters tell the host how many words the DMA deposited before the swap.

## Interface
Parameters:
- AddrBits, 9, word-address width per bank (depth = 2^AddrBits words of 32 bits)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- pushAddress  in  32  DMA write word address; only bits [AddrBits-1:0] are used
- pushData  in  32  DMA write data
- push  in  1  DMA write strobe
- popAddress  in  32  DMA read word address; only bits [AddrBits-1:0] are used
- popData  out  32  DMA read data, registered
- switch  in  1  DMA swap request, one-cycle pulse
- hostAddress  in  AddrBits  host read/write word address
- hostWriteData  in  32  host write data
- hostWrite  in  1  host write strobe
- hostReadData  out  32  host read data, registered
- hostSwitch  in  1  host swap request, one-cycle pulse
- bankSelect  out  1  index of the bank currently on the DMA side
- hostWordCount  out  AddrBits+1  fill count of the host-side bank

## Operation
- Two banks, B0 and B1. The DMA side uses bank bankSelect; the host side uses bank ~bankSelect.
- Swap: if switch or hostSwitch is high at an edge, bankSelect toggles. Both high in the same cycle gives one swap, not two.
- Writes: push writes pushData to DMA-bank[pushAddress]. hostWrite writes hostWriteData to host-bank[hostAddress].
  - A write in the same cycle as a swap goes to the pre-swap bank mapping.
- Reads: every cycle, popData <= DMA-bank[popAddress] and hostReadData <= host-bank[hostAddress]. There is no enable.
  - The read uses the pre-swap mapping in the swap cycle.
  - Same-address read during a write returns the old data (read-first).
- Fill counters: each bank has count[b] of width AddrBits+1.
  - A write (push or hostWrite) at address a sets count[b] = max(count[b], a+1). The maximum value 2^AddrBits is reached naturally.
  - On a swap, the bank moving to the DMA side has its count cleared to 0. The bank moving to the host side keeps its count.
  - If a write and a swap hit the same bank in one cycle, the clear wins for the bank becoming DMA-side. Its data write still happens.
- hostWordCount = count[~bankSelect], combinational from registers.
- Address bits of pushAddress/popAddress above AddrBits-1 are ignored, so addresses wrap modulo depth. They are not an error.
- There is no bounds error, no backpressure, and no busy output. The block is always ready.

## Timing
- Reset (synchronous): bankSelect=0, count[0]=count[1]=0, popData=0, hostReadData=0. Memory contents are not reset.
- Read latency: address presented in cycle N gives data valid after edge N+1.
  - This matches the DMA's ask-then-read sequence of one cycle apart.
- Write latency: data written at edge N is readable by an address presented in cycle N+1 (data out after edge N+2).
- Swap latency: a switch at edge N updates bankSelect and hostWordCount after edge N. Accesses in cycle N+1 use the new mapping.
- Reset asserted mid-operation overrides a simultaneous push, switch, or hostWrite effect on counters and bankSelect.
  - Memory writes in the reset cycle may still occur. They are don't-care.

## Structure
- Shared package dma_pkg holds:
  - default BufAddrBits = 9
  - the buffer depth localparam derived as 1 << BufAddrBits
  - the bank-index type (1 bit)
- One sub-module, dma_buffer_bank: depth 2^AddrBits × 32, one synchronous read port and one write port, read-first. It is instantiated twice.
- The top level holds the port-to-bank muxing, bankSelect, counters and swap logic.

## Test plan
- Reset, then push 0xA5A5_0001..0xA5A5_0004 to addresses 0..3, then switch. Then hostAddress=0..3 → hostReadData 0xA5A5_0001..4 one cycle after each address; hostWordCount=4; bankSelect=1.
- Host writes 0x1234_5678 to address 7, then hostSwitch. popAddress=7 → popData=0x1234_5678 next cycle. The new host bank count is the DMA's previous fill.
- switch and hostSwitch in the same cycle → bankSelect toggles exactly once.
- push to address 2 with switch in the same cycle → data lands in the old DMA bank (now host side): hostReadData at address 2 = pushed value, hostWordCount=3. The new DMA bank count is 0.
- pushAddress=0x0000_0203 with AddrBits=9 → writes word 3. Push at 511 → count=512, no overflow.
- Push and pop at the same address in the same cycle → popData returns the old value. The next pop returns the new value. Reset mid-sequence → bankSelect=0, hostWordCount=0, popData=0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA ping-pong word buffer: default bank geometry
// and the bank-index type.
package dma_pkg;

  localparam int BufAddrBits = 9;
  localparam int BufDepth    = 1 << BufAddrBits;

  typedef logic bank_idx_t;

endpackage

// File: rtl/dma_ping_pong_buffer_if.sv
// Buffer-side bus of the ping-pong buffer: DMA push/pop port, host port, and
// bank status. The "slave" modport is the buffer; "master" drives it.
interface dma_ping_pong_buffer_if
  import dma_pkg::*;
#(
  parameter int AddrBits = BufAddrBits
);

  // There is no handshake: every strobe is accepted in the cycle it is
  // high, and read data is valid one edge after the address is presented.
  logic [31:0]         pushAddress;
  logic [31:0]         pushData;
  logic                push;
  logic [31:0]         popAddress;
  logic [31:0]         popData;
  logic                switch;
  logic [AddrBits-1:0] hostAddress;
  logic [31:0]         hostWriteData;
  logic                hostWrite;
  logic [31:0]         hostReadData;
  logic                hostSwitch;
  bank_idx_t           bankSelect;
  logic [AddrBits:0]   hostWordCount;

  modport slave (
   input  pushAddress, pushData, push, popAddress, switch,
   input  hostAddress, hostWriteData, hostWrite, hostSwitch,
   output popData, hostReadData, bankSelect, hostWordCount
  );

  modport master (
   output pushAddress, pushData, push, popAddress, switch,
   output hostAddress, hostWriteData, hostWrite, hostSwitch,
   input  popData, hostReadData, bankSelect, hostWordCount
  );

endinterface

// File: rtl/dma_buffer_bank.sv
// One 32-bit buffer bank: single write port and single registered read port,
// read-first on a same-address collision.
module dma_buffer_bank #(
   parameter int AddrBits = 9
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                write_enable,
   input  logic [AddrBits-1:0] write_address,
   input  logic [31:0]         write_data,
   input  logic [AddrBits-1:0] read_address,
   output logic [31:0]         read_data
);

   localparam int Depth = 1 << AddrBits;

   logic [31:0] mem [Depth];

   // Memory contents are deliberately left out of reset; only the read
   // register clears so the outputs come up as zero.
   always_ff @(posedge clock) begin
      if (write_enable) begin
         mem[write_address] <= write_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         read_data <= '0;
      end else begin
         read_data <= mem[read_address];
      end
   end

endmodule

// File: rtl/dma_ping_pong_buffer.sv
// Two-bank ping-pong buffer: the DMA side owns bank bankSelect, the host side
// owns the other, and a switch from either side swaps them atomically.
module dma_ping_pong_buffer
   import dma_pkg::*;
#(
   parameter int AddrBits = BufAddrBits
) (
   input  logic                   clock,
   input  logic                   reset,
   dma_ping_pong_buffer_if.slave  bus
);

   localparam int CntBits = AddrBits + 1;

   bank_idx_t bank_sel_q;
   bank_idx_t read_sel_q;
   logic      swap;

   logic [CntBits-1:0]  count_q [2];
   logic [CntBits-1:0]  count_d [2];
   logic [CntBits-1:0]  wr_fill [2];
   logic                wr_en   [2];
   logic [AddrBits-1:0] wr_addr [2];
   logic [31:0]         wr_data [2];
   logic [AddrBits-1:0] rd_addr [2];
   logic [31:0]         rd_data [2];

   logic [AddrBits-1:0] push_addr;
   logic [AddrBits-1:0] pop_addr;
   logic                unused_addr_bits;

   // DMA addresses wrap modulo the bank depth; the upper bits carry no meaning.
   assign push_addr        = bus.pushAddress[AddrBits-1:0];
   assign pop_addr         = bus.popAddress[AddrBits-1:0];
   assign unused_addr_bits = ^{bus.pushAddress[31:AddrBits], bus.popAddress[31:AddrBits]};

   assign swap = bus.switch | bus.hostSwitch;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic dma_side;
      assign dma_side   = (bank_sel_q == bank_idx_t'(b));
      assign wr_en[b]   = dma_side ? bus.push     : bus.hostWrite;
      assign wr_addr[b] = dma_side ? push_addr    : bus.hostAddress;
      assign wr_data[b] = dma_side ? bus.pushData : bus.hostWriteData;
      assign rd_addr[b] = dma_side ? pop_addr     : bus.hostAddress;
      assign wr_fill[b] = {1'b0, wr_addr[b]} + CntBits'(1);

      dma_buffer_bank #(
         .AddrBits (AddrBits)
      ) u_bank (
         .clock         (clock),
         .reset         (reset),
         .write_enable  (wr_en[b]),
         .write_address (wr_addr[b]),
         .write_data    (wr_data[b]),
         .read_address  (rd_addr[b]),
         .read_data     (rd_data[b])
      );
   end

   // High-water mark per bank; the bank handed to the DMA on a swap starts
   // empty even if it was written in the same cycle.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         count_d[b] = count_q[b];
         if (wr_en[b] && (wr_fill[b] > count_q[b])) begin
            count_d[b] = wr_fill[b];
         end
         if (swap && (bank_sel_q != bank_idx_t'(b))) begin
            count_d[b] = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bank_sel_q <= 1'b0;
         read_sel_q <= 1'b0;
         count_q[0] <= '0;
         count_q[1] <= '0;
      end else begin
         bank_sel_q <= bank_sel_q ^ swap;
         read_sel_q <= bank_sel_q;
         count_q[0] <= count_d[0];
         count_q[1] <= count_d[1];
      end
   end

   // Read data is steered by the mapping that was live when the address
   // was sampled, so a swap never tears an in-flight read.
   assign bus.popData       = read_sel_q ? rd_data[1] : rd_data[0];
   assign bus.hostReadData  = read_sel_q ? rd_data[0] : rd_data[1];
   assign bus.bankSelect    = bank_sel_q;
   assign bus.hostWordCount = count_q[~bank_sel_q];

endmodule

// File: tb/tb_dma_ping_pong_buffer.sv
// Directed self-checking bench for dma_ping_pong_buffer with hand-computed
// expected values, one task per scenario.
module tb_dma_ping_pong_buffer;
  import dma_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   passes;
  int   fails;

  dma_ping_pong_buffer_if #(.AddrBits(9)) bus ();

  dma_ping_pong_buffer #(.AddrBits(9)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pushAddress   = '0;
    bus.pushData      = '0;
    bus.push          = 1'b0;
    bus.popAddress    = '0;
    bus.switch        = 1'b0;
    bus.hostAddress   = '0;
    bus.hostWriteData = '0;
    bus.hostWrite     = 1'b0;
    bus.hostSwitch    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.bankSelect !== 1'b0) begin fails++; $display("FAIL reset_bank got %0h exp 0", bus.bankSelect); end else passes++;
    checks++; if (bus.hostWordCount !== 10'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", bus.hostWordCount); end else passes++;
    checks++; if (bus.popData !== 32'h0) begin fails++; $display("FAIL reset_pop got %h exp 0", bus.popData); end else passes++;
    checks++; if (bus.hostReadData !== 32'h0) begin fails++; $display("FAIL reset_host got %h exp 0", bus.hostReadData); end else passes++;
  endtask

  task automatic test_push_switch();
    for (int i = 0; i < 4; i++) begin
      bus.push = 1'b1;
      bus.pushAddress = i;
      bus.pushData = 32'hA5A5_0001 + i;
      tick();
    end
    bus.push = 1'b0;
    bus.switch = 1'b1;
    tick();
    bus.switch = 1'b0;
    checks++; if (bus.bankSelect !== 1'b1) begin fails++; $display("FAIL ps_bank got %0h exp 1", bus.bankSelect); end else passes++;
    checks++; if (bus.hostWordCount !== 10'd4) begin fails++; $display("FAIL ps_count got %0d exp 4", bus.hostWordCount); end else passes++;
    for (int i = 0; i < 4; i++) begin
      bus.hostAddress = 9'(i);
      tick();
      checks++;
      if (bus.hostReadData !== 32'hA5A5_0001 + i) begin
        fails++; $display("FAIL ps_hread[%0d] got %h exp %h", i, bus.hostReadData, 32'hA5A5_0001 + i);
      end else passes++;
    end
  endtask

  task automatic test_host_switch();
    bus.hostWrite = 1'b1;
    bus.hostAddress = 9'd7;
    bus.hostWriteData = 32'h1234_5678;
    bus.push = 1'b1;
    bus.pushAddress = 32'd5;
    bus.pushData = 32'h5555_0005;
    tick();
    bus.hostWrite = 1'b0;
    bus.push = 1'b0;
    checks++; if (bus.hostWordCount !== 10'd8) begin fails++; $display("FAIL hs_precount got %0d exp 8", bus.hostWordCount); end else passes++;
    bus.hostSwitch = 1'b1;
    tick();
    bus.hostSwitch = 1'b0;
    checks++; if (bus.bankSelect !== 1'b0) begin fails++; $display("FAIL hs_bank got %0h exp 0", bus.bankSelect); end else passes++;
    checks++; if (bus.hostWordCount !== 10'd6) begin fails++; $display("FAIL hs_count got %0d exp 6", bus.hostWordCount); end else passes++;
    bus.popAddress = 32'd7;
    tick();
    checks++; if (bus.popData !== 32'h1234_5678) begin fails++; $display("FAIL hs_pop got %h exp 12345678", bus.popData); end else passes++;
  endtask

  task automatic test_dual_switch();
    bus.switch = 1'b1;
    bus.hostSwitch = 1'b1;
    tick();
    bus.switch = 1'b0;
    bus.hostSwitch = 1'b0;
    checks++; if (bus.bankSelect !== 1'b1) begin fails++; $display("FAIL dual_bank got %0h exp 1", bus.bankSelect); end else passes++;
    tick();
    checks++; if (bus.bankSelect !== 1'b1) begin fails++; $display("FAIL dual_hold got %0h exp 1", bus.bankSelect); end else passes++;
  endtask

  task automatic test_push_with_switch();
    // bankSelect is 1: push lands in B1, hostWrite in B0 which turns DMA-side.
    bus.push = 1'b1;
    bus.pushAddress = 32'd2;
    bus.pushData = 32'hCAFE_0002;
    bus.hostWrite = 1'b1;
    bus.hostAddress = 9'd4;
    bus.hostWriteData = 32'hBEEF_0004;
    bus.switch = 1'b1;
    tick();
    bus.push = 1'b0;
    bus.hostWrite = 1'b0;
    bus.switch = 1'b0;
    checks++; if (bus.bankSelect !== 1'b0) begin fails++; $display("FAIL pws_bank got %0h exp 0", bus.bankSelect); end else passes++;
    checks++; if (bus.hostWordCount !== 10'd3) begin fails++; $display("FAIL pws_count got %0d exp 3", bus.hostWordCount); end else passes++;
    bus.hostAddress = 9'd2;
    bus.popAddress = 32'd4;
    tick();
    checks++; if (bus.hostReadData !== 32'hCAFE_0002) begin fails++; $display("FAIL pws_hread got %h exp cafe0002", bus.hostReadData); end else passes++;
    checks++; if (bus.popData !== 32'hBEEF_0004) begin fails++; $display("FAIL pws_pop got %h exp beef0004", bus.popData); end else passes++;
    bus.hostSwitch = 1'b1;
    tick();
    bus.hostSwitch = 1'b0;
    checks++; if (bus.bankSelect !== 1'b1) begin fails++; $display("FAIL pws_bank2 got %0h exp 1", bus.bankSelect); end else passes++;
    checks++; if (bus.hostWordCount !== 10'd0) begin fails++; $display("FAIL pws_clear got %0d exp 0", bus.hostWordCount); end else passes++;
  endtask

  task automatic test_addr_wrap();
    bus.push = 1'b1;
    bus.pushAddress = 32'h0000_0203;
    bus.pushData = 32'h0BAD_0203;
    tick();
    bus.push = 1'b0;
    bus.popAddress = 32'd3;
    tick();
    checks++; if (bus.popData !== 32'h0BAD_0203) begin fails++; $display("FAIL wrap_push got %h exp 0bad0203", bus.popData); end else passes++;
    bus.popAddress = 32'h0000_0403;
    tick();
    checks++; if (bus.popData !== 32'h0BAD_0203) begin fails++; $display("FAIL wrap_pop got %h exp 0bad0203", bus.popData); end else passes++;
    bus.push = 1'b1;
    bus.pushAddress = 32'd511;
    bus.pushData = 32'h5110_0000;
    tick();
    bus.push = 1'b0;
    bus.switch = 1'b1;
    tick();
    bus.switch = 1'b0;
    checks++; if (bus.bankSelect !== 1'b0) begin fails++; $display("FAIL wrap_bank got %0h exp 0", bus.bankSelect); end else passes++;
    checks++; if (bus.hostWordCount !== 10'd512) begin fails++; $display("FAIL wrap_count got %0d exp 512", bus.hostWordCount); end else passes++;
  endtask

  task automatic test_read_first();
    bus.push = 1'b1;
    bus.pushAddress = 32'd10;
    bus.pushData = 32'h1111_1111;
    tick();
    bus.pushData = 32'h2222_2222;
    bus.popAddress = 32'd10;
    tick();
    bus.push = 1'b0;
    checks++; if (bus.popData !== 32'h1111_1111) begin fails++; $display("FAIL rf_old got %h exp 11111111", bus.popData); end else passes++;
    tick();
    checks++; if (bus.popData !== 32'h2222_2222) begin fails++; $display("FAIL rf_new got %h exp 22222222", bus.popData); end else passes++;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    bus.push = 1'b1;
    bus.pushAddress = 32'd20;
    bus.switch = 1'b1;
    bus.hostWrite = 1'b1;
    bus.hostAddress = 9'd30;
    tick();
    reset = 1'b0;
    idle_inputs();
    checks++; if (bus.bankSelect !== 1'b0) begin fails++; $display("FAIL rm_bank got %0h exp 0", bus.bankSelect); end else passes++;
    checks++; if (bus.hostWordCount !== 10'd0) begin fails++; $display("FAIL rm_count got %0d exp 0", bus.hostWordCount); end else passes++;
    checks++; if (bus.popData !== 32'h0) begin fails++; $display("FAIL rm_pop got %h exp 0", bus.popData); end else passes++;
    checks++; if (bus.hostReadData !== 32'h0) begin fails++; $display("FAIL rm_host got %h exp 0", bus.hostReadData); end else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    fails  = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_push_switch();
    test_host_switch();
    test_dual_switch();
    test_push_with_switch();
    test_addr_wrap();
    test_read_first();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
